// File: rtl/alu_mult_unit.sv
// alu_mult_unit: multi-cycle signed multiplier beside the EX-stage ALU.
// Radix-2 shift-add on operand magnitudes, sign applied on the final write.
// Holds the pipeline via stall until the HI/LO product is ready.
// Optional: define MULT_EARLY_TERM_EN to leave RUN once the multiplier is exhausted.
`timescale 1ns/1ps
module alu_mult_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  MULT_CODE = 4'd14
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [3:0]        alu_control,
  input  logic              op_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result_lo,
  output logic [DATA_W-1:0] result_hi
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic                start;
  logic                run_exit;
  logic                neg;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand, acc, acc_nxt, prod_nxt;
  logic [DATA_W-1:0]   mplier, mplier_nxt;
  logic [DATA_W-1:0]   abs_a, abs_b;

  assign start = op_valid && (alu_control == MULT_CODE) && (state == IDLE) && !flush;
  assign stall = start || (state == RUN);
  assign done  = (state == DONE);

  // Operand magnitudes and the next shift-add step of the iteration.
  always_comb begin
    abs_a      = input_a[DATA_W-1] ? -input_a : input_a;
    abs_b      = input_b[DATA_W-1] ? -input_b : input_b;
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mplier_nxt = mplier >> 1;
    prod_nxt   = neg ? -acc_nxt : acc_nxt;
    run_exit   = (cnt == CNT_W'(DATA_W - 1));
`ifdef MULT_EARLY_TERM_EN
    // No multiplier bits left means no further adds can change acc.
    if (mplier_nxt == '0) run_exit = 1'b1;
`endif
  end

  // Next-state logic; flush squashes from any state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)    state_nxt = RUN;
      RUN:  if (run_exit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Datapath: latch operands on start, iterate in RUN, write product on exit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else if (start) begin
      mcand  <= {{DATA_W{1'b0}}, abs_a};
      mplier <= abs_b;
      neg    <= input_a[DATA_W-1] ^ input_b[DATA_W-1];
      acc    <= '0;
      cnt    <= '0;
    end else if ((state == RUN) && !flush) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (run_exit) begin
        result_lo <= prod_nxt[DATA_W-1:0];
        result_hi <= prod_nxt[2*DATA_W-1:DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_unit.sv
// tb_alu_mult_unit: directed bench with a product scoreboard for alu_mult_unit.
`timescale 1ns/1ps
module tb_alu_mult_unit;

  localparam logic [3:0] MULT = 4'd14;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [3:0]  alu_control;
  logic        op_valid;
  logic        flush;
  logic [31:0] input_a, input_b;
  logic        stall, done;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] last_hi, last_lo;
  logic [31:0] long_b;

  alu_mult_unit #(.DATA_W(32), .MULT_CODE(4'd14)) dut (
    .clk(clk), .arst_n(arst_n), .alu_control(alu_control), .op_valid(op_valid),
    .flush(flush), .input_a(input_a), .input_b(input_b), .stall(stall),
    .done(done), .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    sa  = $signed(a);
    sb2 = $signed(b);
    return 64'(sa * sb2);
  endfunction

  function automatic int exp_run(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int r;
    m = b[31] ? -b : b;
    r = 1;
    for (int i = 0; i < 32; i++) if (m[i]) r = i + 1;
    return r;
`else
    return 32;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a multiply in the next cycle and follow it to its done pulse.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
    int n, stalls, run;
    logic [63:0] e;
    step();
    input_a = a; input_b = b; alu_control = MULT; op_valid = 1'b1; flush = 1'b0;
    sb.push_back(model(a, b));
    run = exp_run(b);
    #1;
    check("start_stall", stall, 1);
    check("start_no_done", done, 0);
    n = 0; stalls = 0;
    while (1) begin
      if (stall) stalls++;
      @(posedge clk); #2;
      n++;
      if (done || n >= 100) break;
    end
    check("done_latency", n, run + 1);
    check("stall_cycles", stalls, run + 1);
    check("done_pulse", done, 1);
    check("done_stall_low", stall, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result_hi", result_hi, e[63:32]);
      check("result_lo", result_lo, e[31:0]);
      last_hi = e[63:32];
      last_lo = e[31:0];
    end else begin
      check("scoreboard_nonempty", 0, 1);
    end
  endtask

  initial begin
`ifdef MULT_EARLY_TERM_EN
    long_b = 32'h4000_0005;
`else
    long_b = 32'd5;
`endif
    arst_n = 1'b0; alu_control = 4'd0; op_valid = 1'b0; flush = 1'b0;
    input_a = '0; input_b = '0;
    last_hi = '0; last_lo = '0;
    #12;
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_hi", result_hi, 0);
    check("rst_lo", result_lo, 0);
    step();
    arst_n = 1'b1;

    run_mult(32'd3, 32'd5);
    run_mult(32'hFFFF_FFF9, 32'd6);
    run_mult(32'h8000_0000, 32'h8000_0000);
    run_mult(32'hFFFF_FFFD, 32'd0);

    // Non-multiply codes must leave the unit idle with results held.
    for (int i = 0; i < 5; i++) begin
      step();
      alu_control = 4'd2; op_valid = 1'b1; input_a = 32'd9; input_b = 32'd9;
      #1;
      check("add_stall", stall, 0);
      check("add_done", done, 0);
      check("add_hi", result_hi, last_hi);
      check("add_lo", result_lo, last_lo);
    end

    // Flush in the middle of RUN: no done, results untouched.
    step();
    input_a = 32'd3; input_b = long_b; alu_control = MULT; op_valid = 1'b1;
    #1;
    check("flush_start_stall", stall, 1);
    repeat (10) step();
    flush = 1'b1;
    #1;
    check("flush_run_stall", stall, 1);
    step();
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush_idle_stall", stall, 0);
    check("flush_no_done", done, 0);
    check("flush_hi", result_hi, last_hi);
    check("flush_lo", result_lo, last_lo);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_quiet_done", done, 0);
    end
    run_mult(32'd2, 32'd2);

    // Asynchronous reset in the middle of a run.
    step();
    input_a = 32'd3; input_b = long_b; alu_control = MULT; op_valid = 1'b1;
    repeat (5) step();
    #2;
    arst_n = 1'b0; op_valid = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hi", result_hi, 0);
    check("mid_rst_lo", result_lo, 0);
    step();
    arst_n = 1'b1;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mult(32'd5, 32'h8000_0000);

    step();
    op_valid = 1'b0;
    #1;
    check("final_idle_stall", stall, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mult_unit.md
Name: alu_mult_unit

Overview:
- Multi-cycle signed multiplier in the EX stage, next to the combinational ALU.
- Consumes the 4-bit ALU control code from the ALU-control decoder and starts only on MULT_OP (4'd14).
- Computes a signed DATA_W x DATA_W product with a radix-2 shift-add iteration.
- Holds the pipeline with a stall request until the product is ready, then returns it as HI/LO words to the EX result mux.

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W.
- MULT_CODE, 4'd14, ALU control code that triggers a multiply.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous reset, active low.
- alu_control  in  4  ALU operation code from the ALU-control decoder.
- op_valid  in  1  EX stage holds a valid instruction this cycle.
- flush  in  1  synchronous abort (branch/exception squash).
- input_a  in  DATA_W  rs operand, two's complement.
- input_b  in  DATA_W  rt operand (multiplier), two's complement.
- stall  out  1  hold PC/IF/ID/EX registers.
- done  out  1  one-cycle pulse: result valid.
- result_lo  out  DATA_W  product bits [DATA_W-1:0].
- result_hi  out  DATA_W  product bits [2*DATA_W-1:DATA_W].

Behaviour:
- Reset: single clock clk; reset is asynchronous and active-low on arst_n. State=IDLE, counter=0, all internal registers 0. Outputs: done=0, result_lo=0, result_hi=0, stall=0.
- start = op_valid && alu_control==MULT_CODE && state==IDLE && !flush.
- FSM states: IDLE, RUN, DONE.
- IDLE, on start:
  - latch mcand = |input_a| zero-extended to 2*DATA_W.
  - latch mplier = |input_b| (DATA_W bits, unsigned).
  - latch neg = input_a[MSB]^input_b[MSB].
  - acc=0, cnt=0; go to RUN.
  - |x| of the most negative value is 2^(DATA_W-1), representable unsigned.
- RUN, each cycle:
  - if mplier[0], acc += mcand (mod 2^(2*DATA_W)).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - exit when cnt==DATA_W-1 at that edge: {result_hi,result_lo} <= neg ? -acc_next : acc_next, where acc_next includes this cycle's add; go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE unconditionally. DONE never starts a new operation, even if the same mult is still presented.
- stall = start || state==RUN (combinational). stall is 0 in DONE so the instruction advances with its result.
- Latency: start accepted at cycle T; RUN covers T+1..T+DATA_W; DONE at T+DATA_W+1. stall is high T..T+DATA_W (DATA_W+1 cycles).
- result_hi/lo hold their value until the next RUN->DONE update.
- Non-MULT codes: block stays IDLE, stall=0, outputs unchanged.
- flush: in any state, go to IDLE next edge. done is not asserted and results are not updated. flush && start in IDLE: no start.
- Back-to-back mults: the second one starts in the IDLE cycle after DONE.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: RUN also exits when the post-shift mplier==0. The result is written and DONE follows at the next edge, so latency is data dependent: RUN length = bit position of the highest set bit of |input_b| + 1, minimum 1 cycle (b==0). stall tracks RUN length.
- Undefined: fixed DATA_W RUN cycles, as above.

Test Plan:
- a=3, b=5, alu_control=14, op_valid=1 -> stall high 33 cycles; done at T+33; hi=0x00000000, lo=0x0000000F. With MULT_EARLY_TERM_EN: done at T+4.
- a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- alu_control=2 (ADD), op_valid=1 for 5 cycles -> stall=0, done=0, results unchanged.
- Start 3x5, assert flush at T+10 -> IDLE at T+11, stall=0, no done pulse, results still the previous values. Then start 2x2 -> lo=4.
- arst_n low at T+5 of a run -> all outputs 0 immediately. After release, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0, lo=1.
